// File: rtl/la_pwrseq_pkg.sv
// Shared types for the power-domain sequencer: state encoding and per-state
// decode of the combinational control outputs.
package la_pwrseq_pkg;

    typedef enum logic [3:0] {
        StOff     = 4'd0,
        StPwrOn   = 4'd1,
        StStable  = 4'd2,
        StRelease = 4'd3,
        StRun     = 4'd4,
        StIsolate = 4'd5,
        StSave    = 4'd6,
        StReset   = 4'd7,
        StPwrOff  = 4'd8
    } state_e;

    typedef struct packed {
        logic iso;
        logic pwr_en;
        logic dom_nreset;
        logic busy;
        logic on;
    } ctrl_t;

    localparam ctrl_t CtrlOff = '{iso: 1'b1, pwr_en: 1'b0, dom_nreset: 1'b0,
                                  busy: 1'b0, on: 1'b0};

    function automatic ctrl_t decode(input state_e st);
        ctrl_t c;
        c = CtrlOff;
        case (st)
            StOff: c = CtrlOff;
            StPwrOn, StStable, StReset: begin
                c.pwr_en = 1'b1;
                c.busy   = 1'b1;
            end
            StRelease, StIsolate, StSave: begin
                c.pwr_en     = 1'b1;
                c.dom_nreset = 1'b1;
                c.busy       = 1'b1;
            end
            StRun: begin
                c.iso        = 1'b0;
                c.pwr_en     = 1'b1;
                c.dom_nreset = 1'b1;
                c.on         = 1'b1;
            end
            StPwrOff: c.busy = 1'b1;
            default:  c = CtrlOff;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/la_dsync.sv
// Multi-stage reset-able synchronizer for a single asynchronous bit.
module la_dsync #(
    parameter int SYNC = 2,
    parameter     PROP = "DEFAULT"
) (
    input  logic clk,
    input  logic nreset,
    input  logic din,
    output logic dout
);

    logic [SYNC-1:0] sync_q;

    if (PROP == "DEFAULT") begin : g_std
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) sync_q <= '0;
            else         sync_q <= {sync_q[SYNC-2:0], din};
        end
    end else begin : g_prop
        // Hook for a hardened sync cell; behaviour matches the generic chain.
        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) sync_q <= '0;
            else         sync_q <= {sync_q[SYNC-2:0], din};
        end
    end

    assign dout = sync_q[SYNC-1];

endmodule

// File: rtl/la_pwrseq.sv
// Power-domain sequencer: orders isolation, retention, power switch and domain
// reset for one switchable domain in response to a level power request.
module la_pwrseq
    import la_pwrseq_pkg::*;
#(
    parameter int DLY     = 4,
    parameter int TIMEOUT = 256,
    parameter int SYNC    = 2,
    parameter     PROP    = "DEFAULT"
) (
    input  logic clk,
    input  logic nreset,
    input  logic pwr_req,
    input  logic pwr_ack,
    output logic iso,
    output logic ret,
    output logic pwr_en,
    output logic dom_nreset,
    output logic busy,
    output logic on,
    output logic err
);

    localparam int MaxCnt = (DLY > TIMEOUT) ? DLY : TIMEOUT;
    localparam int CW     = $clog2(MaxCnt + 1);
    localparam logic [CW-1:0] DlyLoad = CW'(DLY - 1);
    localparam logic [CW-1:0] TmoLast = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          err_q, err_d, ret_q, ret_d;
    logic          tmo_q, tmo_d;  // current PWROFF was reached through a power-up timeout
    ctrl_t         ctrl_q;
    logic          ack_s, done, tmo_hit;

    la_dsync #(
        .SYNC (SYNC),
        .PROP (PROP)
    ) u_ack_sync (
        .clk    (clk),
        .nreset (nreset),
        .din    (pwr_ack),
        .dout   (ack_s)
    );

    assign done    = (cnt_q == '0);
    assign tmo_hit = (TIMEOUT > 0) && (cnt_q == TmoLast);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ret_d   = ret_q;
        tmo_d   = tmo_q;
        case (state_q)
            StOff: begin
                if (pwr_req) begin
                    state_d = StPwrOn;
                    cnt_d   = '0;
                end
            end
            StPwrOn: begin
                if (ack_s) begin
                    state_d = StStable;
                    cnt_d   = DlyLoad;
                end else if (tmo_hit) begin
                    state_d = StPwrOff;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StStable: begin
                if (done) begin
                    state_d = StRelease;
                    cnt_d   = DlyLoad;
                    ret_d   = 1'b0;
                end else cnt_d = cnt_q - CW'(1);
            end
            StRelease: begin
                if (done) begin
                    state_d = StRun;
                    err_d   = 1'b0;
                end else cnt_d = cnt_q - CW'(1);
            end
            StRun: begin
                if (!pwr_req) begin
                    state_d = StIsolate;
                    cnt_d   = DlyLoad;
                end
            end
            StIsolate: begin
                if (done) begin
                    state_d = StSave;
                    cnt_d   = DlyLoad;
                    ret_d   = 1'b1;
                end else cnt_d = cnt_q - CW'(1);
            end
            StSave: begin
                if (done) begin
                    state_d = StReset;
                    cnt_d   = DlyLoad;
                end else cnt_d = cnt_q - CW'(1);
            end
            StReset: begin
                if (done) begin
                    state_d = StPwrOff;
                    cnt_d   = '0;
                end else cnt_d = cnt_q - CW'(1);
            end
            StPwrOff: begin
                if (!ack_s) begin
                    state_d = StOff;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                    if (!tmo_q) err_d = 1'b0;
                end else if (tmo_hit) begin
                    state_d = StOff;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StOff;
                cnt_d   = '0;
                tmo_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StOff;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ret_q   <= 1'b0;
            tmo_q   <= 1'b0;
            ctrl_q  <= CtrlOff;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ret_q   <= ret_d;
            tmo_q   <= tmo_d;
            ctrl_q  <= decode(state_d);
        end
    end

    assign iso        = ctrl_q.iso;
    assign pwr_en     = ctrl_q.pwr_en;
    assign dom_nreset = ctrl_q.dom_nreset;
    assign busy       = ctrl_q.busy;
    assign on         = ctrl_q.on;
    assign ret        = ret_q;
    assign err        = err_q;

endmodule

// File: doc/la_pwrseq.md
Name: la_pwrseq

Overview:
- Power-domain sequencer that drives the control side of a switchable domain.
- Outputs: isolation enable (feeds vectorized isolation cells), retention save, power-switch enable and domain reset.
- Orders these signals safely in response to a level power request and a power-switch acknowledge.
- One instance per switchable domain; sits in the always-on domain.

Parameters:
- DLY, 4, settle cycles held in each timed step (>=1)
- TIMEOUT, 256, max cycles waiting for pwr_ack; 0 = wait forever
- SYNC, 2, synchronizer stages on pwr_ack (>=2)
- PROP, "DEFAULT", custom cell property passed to synchronizer

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- pwr_req  input  1  level request: 1 = domain on, 0 = domain off
- pwr_ack  input  1  power-switch acknowledge, asynchronous to clk
- iso  output  1  isolation enable to isolation cells
- ret  output  1  retention save/hold
- pwr_en  output  1  power-switch enable
- dom_nreset  output  1  domain reset, active-low
- busy  output  1  sequence in progress (not RUN/OFF)
- on  output  1  domain fully on (state RUN)
- err  output  1  sticky ack-timeout flag

Behaviour:
- Single clock. Reset is asynchronous, active-low.
- All outputs are registered; the value of each is decoded from the next state, so outputs change on the same edge as the state register.
- Reset state is OFF: iso=1, ret=0, pwr_en=0, dom_nreset=0, busy=0, on=0, err=0, counter=0.
- ack_s is pwr_ack after SYNC flops. Latency is SYNC edges.
- Timed step: the counter loads DLY-1 on entry. The state exits on the edge where counter==0, so each timed step lasts exactly DLY cycles.
- OFF (iso=1, pwr_en=0, dom_nreset=0, ret held): pwr_req=1 sampled at edge k -> PWRON at k; err cleared unless timeout path.
- PWRON (pwr_en=1, iso=1, dom_nreset=0): on ack_s=1 -> STABLE. If TIMEOUT cycles elapse without ack_s -> err=1, go to PWROFF.
- STABLE (timed): -> RELEASE.
- RELEASE (timed; dom_nreset=1, ret=0): -> RUN.
- RUN (iso=0, on=1, busy=0; err cleared on entry): pwr_req=0 sampled -> ISOLATE.
- ISOLATE (timed; iso=1): -> SAVE.
- SAVE (timed; ret=1): -> RESET.
- RESET (timed; dom_nreset=0): -> PWROFF.
- PWROFF (pwr_en=0): on ack_s=0 -> OFF. On TIMEOUT -> err=1, -> OFF anyway.
- ret stays 1 through OFF and PWRON/STABLE. It clears only in RELEASE.
- After reset, ret=0, so the first RELEASE has no restore effect.
- pwr_req is sampled only in RUN and OFF. Toggles mid-sequence are ignored; the sequence always completes, then the level is re-evaluated.
- A pulse shorter than one cycle in RUN/OFF may be missed. This is permitted.
- iso is 1 in every state except RUN. iso never falls while dom_nreset=0 or pwr_en=0.
- Timeout counter: width clog2(max(DLY,TIMEOUT)+1). It saturates without wrap. TIMEOUT=0 disables the check.
- err is sticky until the next entry to RUN, or the next completed power-down reaching OFF without timeout.
- nreset asserted mid-sequence: immediate return to OFF values, including pwr_en=0.
- Illegal state encoding -> OFF on next edge.

Decomposition:
- Package la_pwrseq_pkg: state encoding constants (OFF, PWRON, STABLE, RELEASE, RUN, ISOLATE, SAVE, RESET, PWROFF; 4-bit), and a per-state output-decode function.
- Sub-module: existing la_dsync (SYNC stages, PROP) for pwr_ack.

Test Plan:
All scenarios use DLY=4, SYNC=2, TIMEOUT=16 unless noted; the bench returns pwr_ack one cycle after pwr_en changes.
- Reset then hold pwr_req=0 -> iso=1, pwr_en=0, dom_nreset=0, ret=0, busy=0 indefinitely.
- Power-up:
  - Stimulus: pwr_req 0->1 sampled at edge 0.
  - Response: pwr_en=1 at edge 0. Ack seen at edge ~3. dom_nreset=1 at ack+4. iso=0, on=1 at ack+8. busy high between.
- Power-down from RUN with pwr_req=0 at edge 0 -> iso=1@0, ret=1@4, dom_nreset=0@8, pwr_en=0@12, OFF ~3 edges after ack drops.
- Power-up timeout:
  - Stimulus: pwr_ack stuck 0.
  - Response: err=1 after 16 cycles in PWRON, then pwr_en=0 and OFF; err cleared by the next successful power-up.
- pwr_req toggled 1->0->1 during ISOLATE -> full power-down completes to OFF, then an immediate power-up starts.
- nreset pulsed in SAVE -> all outputs at OFF values asynchronously. Sequencing restarts only from OFF.
